// File: rtl/window_min_cost_sel_if.sv
// Record-in / result-out handshake bundle for window_min_cost_sel.
// The source/consumer side uses master, the selector uses slave.
interface window_min_cost_sel_if #(
    parameter int DSIZE = 8
);
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [DSIZE-1:0]     in_account;
    logic [DSIZE-1:0]     in_A;
    logic [DSIZE-1:0]     in_T;
    logic                 out_valid;
    logic                 out_ready;
    logic [DSIZE-1:0]     out_account;
    logic [2*DSIZE-1:0]   out_cost;

    modport master (
        output clear, in_valid, in_account, in_A, in_T, out_ready,
        input  in_ready, out_valid, out_account, out_cost
    );

    modport slave (
        input  clear, in_valid, in_account, in_A, in_T, out_ready,
        output in_ready, out_valid, out_account, out_cost
    );
endinterface

// File: rtl/window_min_cost_sel.sv
// Sliding-window minimum-cost selector: cost = A*T per record, one registered
// result per accepted record once WIN records are in the window.
module window_min_cost_sel #(
    parameter int DSIZE      = 8,
    parameter int WIN        = 5,
    parameter int TIE_NEWEST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    window_min_cost_sel_if.slave  bus
);
    localparam int DEPTH = WIN - 1;
    localparam int CW    = $clog2(WIN);
    localparam logic [CW-1:0] LAST = CW'(WIN - 1);

    typedef logic [DSIZE-1:0]   acct_t;
    typedef logic [2*DSIZE-1:0] cost_t;
    typedef enum logic {FILL, STREAM} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    acct_t         acct_q [DEPTH];
    acct_t         acct_d [DEPTH];
    cost_t         cost_q [DEPTH];
    cost_t         cost_d [DEPTH];
    logic          out_valid_q, out_valid_d;
    acct_t         out_acct_q, out_acct_d;
    cost_t         out_cost_q, out_cost_d;

    cost_t in_cost;
    logic  accept;
    logic  load;

    acct_t win_acct [WIN];
    cost_t win_cost [WIN];
    acct_t sel_acct;
    cost_t sel_cost;

    assign in_cost      = cost_t'(bus.in_A) * cost_t'(bus.in_T);
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.clear;

    assign bus.out_valid   = out_valid_q;
    assign bus.out_account = out_acct_q;
    assign bus.out_cost    = out_cost_q;

    // Slot 0 is the incoming record, higher slots are progressively older.
    always_comb begin
        win_acct[0] = bus.in_account;
        win_cost[0] = in_cost;
        for (int k = 1; k < WIN; k++) begin
            win_acct[k] = acct_q[k-1];
            win_cost[k] = cost_q[k-1];
        end
    end

    // Scan starting from the preferred end; a strict compare keeps the first
    // record seen among equal costs.
    always_comb begin
        if (TIE_NEWEST != 0) begin
            sel_acct = win_acct[0];
            sel_cost = win_cost[0];
            for (int j = 1; j < WIN; j++) begin
                if (win_cost[j] < sel_cost) begin
                    sel_acct = win_acct[j];
                    sel_cost = win_cost[j];
                end
            end
        end else begin
            sel_acct = win_acct[WIN-1];
            sel_cost = win_cost[WIN-1];
            for (int j = WIN - 2; j >= 0; j--) begin
                if (win_cost[j] < sel_cost) begin
                    sel_acct = win_acct[j];
                    sel_cost = win_cost[j];
                end
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        acct_d      = acct_q;
        cost_d      = cost_q;
        out_valid_d = out_valid_q;
        out_acct_d  = out_acct_q;
        out_cost_d  = out_cost_q;
        load        = 1'b0;

        if (bus.clear) begin
            state_d     = FILL;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (bus.out_ready) out_valid_d = 1'b0;
            if (accept) begin
                acct_d[0] = bus.in_account;
                cost_d[0] = in_cost;
                for (int k = 1; k < DEPTH; k++) begin
                    acct_d[k] = acct_q[k-1];
                    cost_d[k] = cost_q[k-1];
                end
                case (state_q)
                    FILL: begin
                        if (cnt_q == LAST) begin
                            state_d = STREAM;
                            load    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    STREAM: load = 1'b1;
                    default: state_d = FILL;
                endcase
            end
            if (load) begin
                out_valid_d = 1'b1;
                out_acct_d  = sel_acct;
                out_cost_d  = sel_cost;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_acct_q  <= '0;
            out_cost_q  <= '0;
            // NOTE: the window is small flop storage, so it is reset explicitly rather than left unknown.
            for (int k = 0; k < DEPTH; k++) begin
                acct_q[k] <= '0;
                cost_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_acct_q  <= out_acct_d;
            out_cost_q  <= out_cost_d;
            for (int k = 0; k < DEPTH; k++) begin
                acct_q[k] <= acct_d[k];
                cost_q[k] <= cost_d[k];
            end
        end
    end
endmodule

// File: tb/tb_window_min_cost_sel.sv
// Self-checking bench: two selectors (newest-wins and oldest-wins) share one
// stimulus stream and are compared against a queue-based window model.
module tb_window_min_cost_sel;
    localparam int DSIZE = 8;
    localparam int WIN   = 5;

    typedef struct {
        logic [7:0]  acct;
        logic [15:0] cost;
    } rec_t;

    typedef struct {
        logic [7:0]  a1;
        logic [15:0] c1;
        logic [7:0]  a0;
        logic [15:0] c0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_account = '0;
    logic [7:0] in_A = '0;
    logic [7:0] in_T = '0;
    int         mode = 0;   // 0: always ready, 1: random ready, 2: stalled

    int n_checks = 0;
    int n_pass = 0;
    int n_results = 0;

    rec_t win_q[$];
    exp_t exp_q[$];

    window_min_cost_sel_if #(.DSIZE(DSIZE)) bus1 ();
    window_min_cost_sel_if #(.DSIZE(DSIZE)) bus0 ();

    assign bus1.clear = clear;      assign bus0.clear = clear;
    assign bus1.in_valid = in_valid; assign bus0.in_valid = in_valid;
    assign bus1.in_account = in_account; assign bus0.in_account = in_account;
    assign bus1.in_A = in_A;        assign bus0.in_A = in_A;
    assign bus1.in_T = in_T;        assign bus0.in_T = in_T;
    assign bus1.out_ready = out_ready; assign bus0.out_ready = out_ready;

    window_min_cost_sel #(.DSIZE(DSIZE), .WIN(WIN), .TIE_NEWEST(1)) dut_new (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    window_min_cost_sel #(.DSIZE(DSIZE), .WIN(WIN), .TIE_NEWEST(0)) dut_old (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    // Reference: minimum over the last WIN records, oldest-first scan.
    function automatic exp_t model_result();
        exp_t e;
        e.a1 = win_q[0].acct; e.c1 = win_q[0].cost;
        e.a0 = win_q[0].acct; e.c0 = win_q[0].cost;
        for (int i = 1; i < win_q.size(); i++) begin
            if (win_q[i].cost <= e.c1) begin e.a1 = win_q[i].acct; e.c1 = win_q[i].cost; end
            if (win_q[i].cost <  e.c0) begin e.a0 = win_q[i].acct; e.c0 = win_q[i].cost; end
        end
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Compare process: inputs and outputs are stable at the falling edge.
    initial begin
        logic        hold_v;
        logic [7:0]  hold_a;
        logic [15:0] hold_c;
        exp_t        e;
        rec_t        r;
        hold_v = 1'b0; hold_a = '0; hold_c = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                win_q.delete(); exp_q.delete(); n_results = 0; hold_v = 1'b0;
            end else begin
                check("in_ready", bus1.in_ready, !bus1.out_valid || out_ready);
                check("valid_new", bus1.out_valid, exp_q.size() > 0);
                check("valid_old", bus0.out_valid, exp_q.size() > 0);
                if (hold_v) begin
                    check("hold_acct", bus1.out_account, hold_a);
                    check("hold_cost", bus1.out_cost, hold_c);
                end
                hold_v = bus1.out_valid && !out_ready && !clear;
                hold_a = bus1.out_account;
                hold_c = bus1.out_cost;
                if (clear) begin
                    win_q.delete(); exp_q.delete(); n_results = 0;
                end else begin
                    if (bus1.out_valid && out_ready && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("acct_new", bus1.out_account, e.a1);
                        check("cost_new", bus1.out_cost, e.c1);
                        check("acct_old", bus0.out_account, e.a0);
                        check("cost_old", bus0.out_cost, e.c0);
                        n_results++;
                    end
                    if (in_valid && bus1.in_ready) begin
                        r.acct = in_account;
                        r.cost = 16'(int'(in_A) * int'(in_T));
                        win_q.push_back(r);
                        if (win_q.size() > WIN) void'(win_q.pop_front());
                        if (win_q.size() == WIN) exp_q.push_back(model_result());
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] acct, input logic [7:0] a, input logic [7:0] t);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; in_account = acct; in_A = a; in_T = t;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = bus1.in_ready && !clear;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic send_random(input int i);
        logic [7:0] a, t;
        if ($urandom_range(0, 1) != 0) begin
            a = 8'($urandom_range(0, 3)); t = 8'($urandom_range(0, 3));
        end else begin
            a = 8'($urandom_range(0, 255)); t = 8'($urandom_range(0, 255));
        end
        send(8'(i), a, t);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        check("reset_valid", bus1.out_valid, 0);
        check("reset_ready", bus1.in_ready, 1);

        // Asynchronous reset in the middle of a stream.
        for (int k = 1; k <= 7; k++) send(8'(k), 8'(k + 2), 8'(9 - k));
        #1;
        check("pre_reset_valid", bus1.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_valid", bus1.out_valid, 0);
        check("rst_acct", bus1.out_account, 0);
        check("rst_cost", bus1.out_cost, 0);
        idle(1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) send(8'(50 + k), 8'(k), 8'(3));
        idle(2);
        check("refill_no_out", bus1.out_valid, 0);
        do_clear();

        // Costs 9,4,7,4,8,1 on accounts 10..15.
        send(10, 3, 3); send(11, 2, 2); send(12, 7, 1); send(13, 4, 1);
        check("fill4_no_out", bus1.out_valid, 0);
        send(14, 2, 4);
        check("w1_valid", bus1.out_valid, 1);
        check("w1_acct_new", bus1.out_account, 13);
        check("w1_cost_new", bus1.out_cost, 4);
        check("w1_acct_old", bus0.out_account, 11);
        check("w1_cost_old", bus0.out_cost, 4);
        send(15, 1, 1);
        check("w2_acct_new", bus1.out_account, 15);
        check("w2_cost_new", bus1.out_cost, 1);
        check("w2_acct_old", bus0.out_account, 15);
        do_clear();

        // Maximum operands, all costs equal.
        for (int k = 20; k <= 24; k++) send(8'(k), 8'd255, 8'd255);
        check("max_cost", bus1.out_cost, 65025);
        check("max_acct_new", bus1.out_account, 24);
        check("max_acct_old", bus0.out_account, 20);
        send(25, 255, 255);
        check("max2_acct_new", bus1.out_account, 25);
        check("max2_acct_old", bus0.out_account, 21);
        do_clear();

        // clear beats a simultaneous record.
        for (int k = 30; k <= 36; k++) send(8'(k), 8'(k % 7), 8'(k % 5));
        in_valid = 1'b1; in_account = 99; in_A = 0; in_T = 0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        check("clear_valid", bus1.out_valid, 0);
        for (int k = 40; k <= 43; k++) send(8'(k), 8'(k % 9), 8'(3));
        idle(2);
        check("clear_refill_no_out", bus1.out_valid, 0);
        send(44, 1, 1);
        check("clear_refill_out", bus1.out_valid, 1);
        idle(1);
        do_clear();

        // Long randomized stream with backpressure.
        mode = 1;
        i = 0;
        while (i < 4000) begin
            if (i == 2000) begin
                mode = 0;
                idle(2);
                mode = 2;
                send_random(i);
                i++;
                in_valid = 1'b1; in_account = 8'(i); in_A = 8'd6; in_T = 8'd7;
                repeat (10) begin
                    @(negedge clk); #1;
                    check("bp_in_ready", bus1.in_ready, 0);
                    check("bp_valid", bus1.out_valid, 1);
                end
                mode = 1;
                send(8'(i), 8'd6, 8'd7);
                i++;
            end else begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send_random(i);
                i++;
            end
        end
        mode = 0;
        idle(4);
        check("stream_results", n_results, 3996);
        check("drained", bus1.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
